// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: counters, syncs, blanks, data-enable and strobes.
// Optional frame counter enabled by defining VGA_TIMING_GEN_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE    = 1024,
    parameter int H_FP        = 24,
    parameter int H_SYNC      = 136,
    parameter int H_BP        = 160,
    parameter int V_ACTIVE    = 768,
    parameter int V_FP        = 3,
    parameter int V_SYNC      = 6,
    parameter int V_BP        = 29,
    parameter int H_SYNC_POL  = 1,
    parameter int V_SYNC_POL  = 1,
    parameter int CNT_W       = 11,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic [CNT_W-1:0]       hcount,
    output logic [CNT_W-1:0]       vcount,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   hblnk,
    output logic                   vblnk,
    output logic                   de,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [11:0]            rgb
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SS  = H_ACTIVE + H_FP;
    localparam int H_SE  = H_SS + H_SYNC;
    localparam int V_SS  = V_ACTIVE + V_FP;
    localparam int V_SE  = V_SS + V_SYNC;
    localparam logic H_POL = (H_SYNC_POL != 0);
    localparam logic V_POL = (V_SYNC_POL != 0);

    generate
        if ((2 ** CNT_W) < H_TOT || (2 ** CNT_W) < V_TOT) begin : g_cnt_w_err
            $error("vga_timing_gen: CNT_W too small for the configured totals");
        end
        if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_err
            $error("vga_timing_gen: porch and sync widths must be non-zero");
        end
    endgenerate

    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             hb_next;
    logic             vb_next;
    logic             hs_raw;
    logic             vs_raw;

    // Flags are derived from the next counts so they land in the same cycle as the counts.
    always_comb begin
        h_next = hcount + CNT_W'(1);
        v_next = vcount;
        if (hcount == CNT_W'(H_TOT - 1)) begin
            h_next = '0;
            if (vcount == CNT_W'(V_TOT - 1)) begin
                v_next = '0;
            end else begin
                v_next = vcount + CNT_W'(1);
            end
        end
        hb_next = (h_next >= CNT_W'(H_ACTIVE));
        vb_next = (v_next >= CNT_W'(V_ACTIVE));
        hs_raw  = (h_next >= CNT_W'(H_SS)) && (h_next < CNT_W'(H_SE));
        vs_raw  = (v_next >= CNT_W'(V_SS)) && (v_next < CNT_W'(V_SE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            de          <= 1'b1;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            hcount      <= h_next;
            vcount      <= v_next;
            hblnk       <= hb_next;
            vblnk       <= vb_next;
            de          <= !hb_next && !vb_next;
            hsync       <= hs_raw ? H_POL : ~H_POL;
            vsync       <= vs_raw ? V_POL : ~V_POL;
            line_start  <= (h_next == '0);
            frame_start <= (h_next == '0) && (v_next == '0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    // Increments alongside frame_start so the new value appears with the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (en && h_next == '0 && v_next == '0) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end
`else
    assign frame_cnt = '0;
`endif

    assign rgb = 12'h000;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-mode instance with table-driven checks and a small
// active-low instance compared every cycle against a position-based reference model.
module tb_vga_timing_gen;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif
    localparam int S_HT = 16;
    localparam int S_VT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d, en_d, rst_s, en_s;
    logic [10:0] hcount_d, vcount_d;
    logic        hsync_d, vsync_d, hblnk_d, vblnk_d, de_d, line_start_d, frame_start_d;
    logic [7:0]  frame_cnt_d;
    logic [11:0] rgb_d;
    logic [4:0]  hcount_s, vcount_s;
    logic        hsync_s, vsync_s, hblnk_s, vblnk_s, de_s, line_start_s, frame_start_s;
    logic [7:0]  frame_cnt_s;
    logic [11:0] rgb_s;

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst_d), .en(en_d),
        .hcount(hcount_d), .vcount(vcount_d), .hsync(hsync_d), .vsync(vsync_d),
        .hblnk(hblnk_d), .vblnk(vblnk_d), .de(de_d),
        .line_start(line_start_d), .frame_start(frame_start_d),
        .frame_cnt(frame_cnt_d), .rgb(rgb_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .CNT_W(5), .FRAME_CNT_W(8)
    ) dut_s (
        .clk(clk), .rst(rst_s), .en(en_s),
        .hcount(hcount_s), .vcount(vcount_s), .hsync(hsync_s), .vsync(vsync_s),
        .hblnk(hblnk_s), .vblnk(vblnk_s), .de(de_s),
        .line_start(line_start_s), .frame_start(frame_start_s),
        .frame_cnt(frame_cnt_s), .rgb(rgb_s)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: position = enabled steps since reset, modulo the frame length.
    int m_pos    = 0;
    int m_frames = 0;
    bit m_ls     = 0;
    bit m_fs     = 0;

    function automatic logic [24:0] model_vec();
        int hc, vc;
        logic hs, vs, hb, vb;
        logic [7:0] fc;
        hc = m_pos % S_HT;
        vc = m_pos / S_HT;
        hs = !(hc >= 10 && hc < 12);
        vs = !(vc == 5);
        hb = (hc >= 8);
        vb = (vc >= 4);
        fc = FC_EN ? 8'(m_frames % 256) : 8'd0;
        return {5'(hc), 5'(vc), hs, vs, hb, vb, !hb && !vb, m_ls, m_fs, fc};
    endfunction

    function automatic logic [24:0] dut_s_vec();
        return {hcount_s, vcount_s, hsync_s, vsync_s, hblnk_s, vblnk_s, de_s,
                line_start_s, frame_start_s, frame_cnt_s};
    endfunction

    task automatic s_cycle(input bit r, input bit e);
        rst_s = r;
        en_s  = e;
        tick();
        if (r) begin
            m_pos = 0; m_frames = 0; m_ls = 0; m_fs = 0;
        end else if (e) begin
            m_pos = (m_pos + 1) % (S_HT * S_VT);
            m_ls  = (m_pos % S_HT == 0);
            m_fs  = (m_pos == 0);
            if (m_fs) m_frames++;
        end else begin
            m_ls = 0; m_fs = 0;
        end
        check("small_model", 32'(dut_s_vec()), 32'(model_vec()));
    endtask

    int hs_cnt = 0, hs_first = -1, hs_last = -1;

    task automatic d_tick();
        tick();
        if (hsync_d && vcount_d == 11'd0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(hcount_d);
            hs_last = int'(hcount_d);
        end
    endtask

    task automatic run_d_to(input int h, input int budget);
        int n = 0;
        while (int'(hcount_d) != h && n < budget) begin
            d_tick();
            n++;
        end
        check("reach_hcount", 32'(hcount_d), 32'(h));
    endtask

    typedef struct { int h; logic exp_hs; logic exp_hb; } flag_vec_t;
    typedef struct { logic en; int exp_h; logic exp_ls; } en_vec_t;
    flag_vec_t flag_tab[7];
    en_vec_t   en_tab[4];

    initial begin
        int n, hs_low, vs_low;
        flag_tab[0] = '{1023, 1'b0, 1'b0};
        flag_tab[1] = '{1024, 1'b0, 1'b1};
        flag_tab[2] = '{1047, 1'b0, 1'b1};
        flag_tab[3] = '{1048, 1'b1, 1'b1};
        flag_tab[4] = '{1183, 1'b1, 1'b1};
        flag_tab[5] = '{1184, 1'b0, 1'b1};
        flag_tab[6] = '{1343, 1'b0, 1'b1};
        en_tab[0] = '{1'b1, 501, 1'b0};
        en_tab[1] = '{1'b0, 501, 1'b0};
        en_tab[2] = '{1'b0, 501, 1'b0};
        en_tab[3] = '{1'b1, 502, 1'b0};

        rst_d = 1'b1; en_d = 1'b1; rst_s = 1'b1; en_s = 1'b0;
        repeat (3) tick();
        check("d_reset_vec",
              32'({hcount_d, vcount_d, hsync_d, vsync_d, hblnk_d, vblnk_d, de_d,
                   line_start_d, frame_start_d}),
              32'({11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
        check("d_reset_frame_cnt", 32'(frame_cnt_d), 32'd0);
        check("d_rgb", 32'(rgb_d), 32'd0);

        rst_d = 1'b0;
        d_tick();
        check("d_first_hcount", 32'(hcount_d), 32'd1);
        check("d_first_vcount", 32'(vcount_d), 32'd0);
        check("d_first_strobes", 32'({line_start_d, frame_start_d}), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_d_to(flag_tab[i].h, 2000);
            check("d_hsync_at", 32'(hsync_d), 32'(flag_tab[i].exp_hs));
            check("d_hblnk_at", 32'(hblnk_d), 32'(flag_tab[i].exp_hb));
            check("d_de_at", 32'(de_d), 32'(!flag_tab[i].exp_hb));
        end
        check("d_hsync_count", 32'(hs_cnt), 32'd136);
        check("d_hsync_first", 32'(hs_first), 32'd1048);
        check("d_hsync_last", 32'(hs_last), 32'd1183);
        check("d_line0_vcount", 32'(vcount_d), 32'd0);

        d_tick();
        check("d_wrap_hcount", 32'(hcount_d), 32'd0);
        check("d_wrap_vcount", 32'(vcount_d), 32'd1);
        check("d_wrap_line_start", 32'(line_start_d), 32'd1);
        check("d_wrap_frame_start", 32'(frame_start_d), 32'd0);
        check("d_wrap_flags", 32'({hsync_d, hblnk_d, de_d}), 32'b001);

        run_d_to(500, 2000);
        for (int i = 0; i < 4; i++) begin
            en_d = en_tab[i].en;
            d_tick();
            check("d_en_hcount", 32'(hcount_d), 32'(en_tab[i].exp_h));
            check("d_en_line_start", 32'(line_start_d), 32'(en_tab[i].exp_ls));
            check("d_en_frame_start", 32'(frame_start_d), 32'd0);
        end
        en_d = 1'b1;

        run_d_to(700, 2000);
        rst_d = 1'b1;
        d_tick();
        check("d_midreset_vec",
              32'({hcount_d, vcount_d, hsync_d, vsync_d, hblnk_d, vblnk_d, de_d,
                   line_start_d, frame_start_d}),
              32'({11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
        rst_d = 1'b0;
        d_tick();
        check("d_after_reset_hcount", 32'(hcount_d), 32'd1);
        check("d_after_reset_strobes", 32'({line_start_d, frame_start_d}), 32'd0);
        run_d_to(0, 2000);
        check("d_after_reset_wrap",
              32'({vcount_d, line_start_d, frame_start_d}), 32'({11'd1, 1'b1, 1'b0}));
        rst_d = 1'b1;

        // Small active-low mode.
        repeat (3) s_cycle(1'b1, 1'b1);
        repeat (127) s_cycle(1'b0, 1'b1);
        check("s_last_pos", 32'({hcount_s, vcount_s}), 32'({5'd15, 5'd7}));
        s_cycle(1'b0, 1'b1);
        check("s_frame_wrap",
              32'({hcount_s, vcount_s, line_start_s, frame_start_s, de_s}),
              32'({5'd0, 5'd0, 1'b1, 1'b1, 1'b1}));
        check("s_frame_cnt_first", 32'(frame_cnt_s), FC_EN ? 32'd1 : 32'd0);

        n = 0; hs_low = 0; vs_low = 0;
        do begin
            s_cycle(1'b0, 1'b1);
            n++;
            if (!hsync_s) hs_low++;
            if (!vsync_s) vs_low++;
        end while (!frame_start_s && n < 300);
        check("s_period", 32'(n), 32'(S_HT * S_VT));
        check("s_hsync_low_cycles", 32'(hs_low), 32'd16);
        check("s_vsync_low_cycles", 32'(vs_low), 32'd16);

        n = 0;
        while (!(hcount_s == 5'd5 && vcount_s == 5'd3) && n < 300) begin
            s_cycle(1'b0, 1'b1);
            n++;
        end
        check("s_reach_mid", 32'({hcount_s, vcount_s}), 32'({5'd5, 5'd3}));
        s_cycle(1'b1, 1'b1);
        check("s_midreset_pos", 32'({hcount_s, vcount_s}), 32'd0);

        for (int i = 0; i < 6000; i++) begin
            s_cycle($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0);
        end

        s_cycle(1'b1, 1'b1);
        n = 0;
        while (m_frames < 255 && n < 60000) begin
            s_cycle(1'b0, $urandom_range(0, 7) != 0);
            n++;
        end
        check("s_frames_255", 32'(frame_cnt_s), FC_EN ? 32'd255 : 32'd0);
        while (m_frames < 256 && n < 60000) begin
            s_cycle(1'b0, $urandom_range(0, 7) != 0);
            n++;
        end
        check("s_frames_budget", 32'(m_frames), 32'd256);
        check("s_frame_cnt_wrap", 32'(frame_cnt_s), 32'd0);
        check("s_rgb", 32'(rgb_s), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
